// File: rtl/wakeup_debounce.sv
`default_nettype none
// ============================================================================
// Module      : wakeup_debounce
// Description : Synchronises and debounces the active-low MCU_WAKE pad into
//               the hfclk domain, enforces a minimum asserted low width and
//               emits single-cycle press/release strobes.
//               Optional macro WAKEUP_DB_GLITCH_CNT_EN adds a saturating
//               bounce-rejection counter (glitch_cnt) with a clear (glitch_clr).
// Revision    : 1.0 - initial release
// ============================================================================
module wakeup_debounce #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 20,
    parameter int unsigned DB_CYCLES   = 80000,
    parameter int unsigned HOLD_CYCLES = 16000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pad_n_i,
    output logic       dwakeup_n,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       busy
`ifdef WAKEUP_DB_GLITCH_CNT_EN
    ,
    input  logic       glitch_clr,
    output logic [7:0] glitch_cnt
`endif
);

    typedef enum logic [2:0] {
        ST_REL      = 3'd0,
        ST_CHK_LOW  = 3'd1,
        ST_HOLD     = 3'd2,
        ST_LOW      = 3'd3,
        ST_CHK_HIGH = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] C_ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_DB_LAST   = CNT_W'(DB_CYCLES);
    localparam logic [CNT_W-1:0] C_HOLD_LAST = (HOLD_CYCLES == 0) ? '0 : CNT_W'(HOLD_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   w_sync;

    state_t                 state_q;
    state_t                 state_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   dwakeup_n_q;
    logic                   dwakeup_n_d;
    logic                   press_q;
    logic                   press_d;
    logic                   release_q;
    logic                   release_d;

    // Plain shift chain: each stage is a bare flop so metastability can settle.
    assign sync_d = {sync_q[SYNC_STAGES-2:0], pad_n_i};
    assign w_sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q      <= '1;
            state_q     <= ST_REL;
            cnt_q       <= '0;
            dwakeup_n_q <= 1'b1;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dwakeup_n_q <= dwakeup_n_d;
            press_q     <= press_d;
            release_q   <= release_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dwakeup_n_d = dwakeup_n_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        case (state_q)
            ST_REL: begin
                dwakeup_n_d = 1'b1;
                if (!w_sync) begin
                    state_d = ST_CHK_LOW;
                    cnt_d   = C_ONE;
                end
            end
            ST_CHK_LOW: begin
                if (w_sync) begin
                    state_d = ST_REL;
                    cnt_d   = '0;
                end else if (cnt_q == C_DB_LAST) begin
                    state_d     = (HOLD_CYCLES == 0) ? ST_LOW : ST_HOLD;
                    cnt_d       = '0;
                    dwakeup_n_d = 1'b0;
                    press_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q + C_ONE;
                end
            end
            ST_HOLD: begin
                // Pad level is deliberately ignored until the hold expires.
                dwakeup_n_d = 1'b0;
                if (cnt_q == C_HOLD_LAST) begin
                    state_d = ST_LOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + C_ONE;
                end
            end
            ST_LOW: begin
                dwakeup_n_d = 1'b0;
                if (w_sync) begin
                    state_d = ST_CHK_HIGH;
                    cnt_d   = C_ONE;
                end
            end
            ST_CHK_HIGH: begin
                if (!w_sync) begin
                    state_d = ST_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == C_DB_LAST) begin
                    state_d     = ST_REL;
                    cnt_d       = '0;
                    dwakeup_n_d = 1'b1;
                    release_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + C_ONE;
                end
            end
            default: begin
                state_d     = ST_REL;
                cnt_d       = '0;
                dwakeup_n_d = 1'b1;
            end
        endcase
    end

    always_comb begin
        busy = (state_q == ST_CHK_LOW) || (state_q == ST_HOLD) || (state_q == ST_CHK_HIGH);
    end

    assign dwakeup_n     = dwakeup_n_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;

`ifdef WAKEUP_DB_GLITCH_CNT_EN
    logic       w_reject;
    logic [7:0] glitch_q;
    logic [7:0] glitch_d;

    assign w_reject = ((state_q == ST_CHK_LOW)  &&  w_sync) ||
                      ((state_q == ST_CHK_HIGH) && !w_sync);

    always_comb begin
        glitch_d = glitch_q;
        if (glitch_clr) begin
            glitch_d = '0;
        end else if (w_reject && (glitch_q != 8'hFF)) begin
            glitch_d = glitch_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            glitch_q <= '0;
        end else begin
            glitch_q <= glitch_d;
        end
    end

    assign glitch_cnt = glitch_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wakeup_debounce.sv
`default_nettype none
// ============================================================================
// Module      : tb_wakeup_debounce
// Description : Self-checking bench for wakeup_debounce (SYNC_STAGES=2,
//               DB_CYCLES=4, HOLD_CYCLES=8); glitch counter checks are
//               compiled in when WAKEUP_DB_GLITCH_CNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wakeup_debounce;

    logic       clk     = 1'b0;
    logic       reset   = 1'b1;
    logic       pad_n_i = 1'b0;
    logic       dwakeup_n;
    logic       press_pulse;
    logic       release_pulse;
    logic       busy;
`ifdef WAKEUP_DB_GLITCH_CNT_EN
    logic       glitch_clr = 1'b0;
    logic [7:0] glitch_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic pad;
        logic dw;
        logic pr;
        logic rl;
        logic bz;
    } vec_t;

    vec_t vecs[$];

    wakeup_debounce #(
        .SYNC_STAGES (2),
        .CNT_W       (20),
        .DB_CYCLES   (4),
        .HOLD_CYCLES (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pad_n_i       (pad_n_i),
        .dwakeup_n     (dwakeup_n),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .busy          (busy)
`ifdef WAKEUP_DB_GLITCH_CNT_EN
        ,
        .glitch_clr    (glitch_clr),
        .glitch_cnt    (glitch_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input int n, input logic pad, input logic dw,
                        input logic pr, input logic rl, input logic bz);
        vec_t v;
        v.pad = pad; v.dw = dw; v.pr = pr; v.rl = rl; v.bz = bz;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    task automatic wait_dw(input logic val, input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(posedge clk); #1;
            if (dwakeup_n == val) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

`ifdef WAKEUP_DB_GLITCH_CNT_EN
    // Pad 0,0,1,1,1 over five edges: enters CHK_LOW on edge 2, rejected on edge 4.
    task automatic bounce_once(input bit clr_at_reject);
        for (int e = 0; e < 5; e++) begin
            @(negedge clk);
            pad_n_i    = (e < 2) ? 1'b0 : 1'b1;
            glitch_clr = clr_at_reject && (e == 4);
            @(posedge clk); #1;
        end
        @(negedge clk);
        glitch_clr = 1'b0;
    endtask
`endif

    initial begin
        bit ok;
        int fall;
        int rise;
        int npress;
        int nrel;

        // ---- Test 1: reset held with pad low, then released
        reset   = 1'b1;
        pad_n_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("t1_in_reset", {dwakeup_n, press_pulse, release_pulse, busy}, 4'b1000);
        @(negedge clk);
        reset = 1'b0;
        for (int e = 0; e < 8; e++) begin
            @(posedge clk); #1;
            check($sformatf("t1_edge%0d", e), {dwakeup_n, press_pulse, release_pulse, busy},
                  {(e >= 6) ? 1'b0 : 1'b1, (e == 6) ? 1'b1 : 1'b0, 1'b0, (e >= 2) ? 1'b1 : 1'b0});
        end
        @(negedge clk);
        pad_n_i = 1'b1;
        wait_dw(1'b1, 60, ok);
        check("t1_return_high", ok, 1);
        repeat (3) @(posedge clk);

        // ---- Tests 2 and 3: per-edge vector table {pad, dw, press, release, busy}
        // Clean press held 30 cycles, then clean release.
        push(2,  0, 1, 0, 0, 0);
        push(4,  0, 1, 0, 0, 1);
        push(1,  0, 0, 1, 0, 1);
        push(7,  0, 0, 0, 0, 1);
        push(16, 0, 0, 0, 0, 0);
        push(2,  1, 0, 0, 0, 0);
        push(4,  1, 0, 0, 0, 1);
        push(1,  1, 1, 0, 1, 0);
        push(3,  1, 1, 0, 0, 0);
        // Bounce 0,0,1,1,0,0,1,1 then stable low, then release.
        push(2,  0, 1, 0, 0, 0);
        push(2,  1, 1, 0, 0, 1);
        push(2,  0, 1, 0, 0, 0);
        push(2,  1, 1, 0, 0, 1);
        push(2,  0, 1, 0, 0, 0);
        push(4,  0, 1, 0, 0, 1);
        push(1,  0, 0, 1, 0, 1);
        push(7,  0, 0, 0, 0, 1);
        push(2,  1, 0, 0, 0, 0);
        push(4,  1, 0, 0, 0, 1);
        push(1,  1, 1, 0, 1, 0);
        push(2,  1, 1, 0, 0, 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            pad_n_i = vecs[i].pad;
            @(posedge clk); #1;
            check($sformatf("vec%0d", i), {dwakeup_n, press_pulse, release_pulse, busy},
                  {vecs[i].dw, vecs[i].pr, vecs[i].rl, vecs[i].bz});
        end
`ifdef WAKEUP_DB_GLITCH_CNT_EN
        check("t3_glitch_cnt", glitch_cnt, 2);
`endif

        // ---- Test 4: release during HOLD stretches low width to HOLD+DB+1
        fall = -1; rise = -1; npress = 0; nrel = 0;
        for (int e = 0; e < 40; e++) begin
            @(negedge clk);
            pad_n_i = (e < 9) ? 1'b0 : 1'b1;
            @(posedge clk); #1;
            if (press_pulse) npress++;
            if (release_pulse) nrel++;
            if (fall < 0 && !dwakeup_n) fall = e;
            if (fall >= 0 && rise < 0 && dwakeup_n) rise = e;
        end
        check("t4_fall_edge", fall, 6);
        check("t4_low_width", rise - fall, 13);
        check("t4_press_count", npress, 1);
        check("t4_release_count", nrel, 1);

        // ---- Test 5: asynchronous reset while in CHK_HIGH
        @(negedge clk);
        pad_n_i = 1'b0;
        wait_dw(1'b0, 40, ok);
        check("t5_press_seen", ok, 1);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        check("t5_reach_low", ok, 1);
        @(negedge clk);
        pad_n_i = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("t5_in_chk_high", {dwakeup_n, busy}, 2'b01);
        #2 reset = 1'b1;
        #1;
        check("t5_async_reset", {dwakeup_n, press_pulse, release_pulse, busy}, 4'b1000);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check($sformatf("t5_hold_rst%0d", i), {dwakeup_n, release_pulse}, 2'b10);
        end
`ifdef WAKEUP_DB_GLITCH_CNT_EN
        check("t5_glitch_reset", glitch_cnt, 0);
`endif
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check($sformatf("t5_idle%0d", i), {dwakeup_n, press_pulse, release_pulse, busy}, 4'b1000);
        end

`ifdef WAKEUP_DB_GLITCH_CNT_EN
        // ---- Test 6: clear vs. increment, then saturation
        bounce_once(1'b0);
        check("t6_one_reject", glitch_cnt, 1);
        bounce_once(1'b1);
        check("t6_clear_wins", glitch_cnt, 0);
        @(posedge clk); #1;
        check("t6_clear_holds", glitch_cnt, 0);
        for (int i = 0; i < 300; i++) begin
            bounce_once(1'b0);
            if (i == 254) check("t6_reach_255", glitch_cnt, 255);
        end
        check("t6_saturated", glitch_cnt, 255);
        check("t6_output_idle", {dwakeup_n, busy}, 2'b10);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
